// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC-SP16 types and constants
package wisc_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_ENC      = 16'h0800;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_VALID  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read bus between fetch and memory
interface fetch_unit_if;
  import wisc_pkg::*;

  logic               MemRd;
  logic [INSTR_W-1:0] MemAddr;
  logic [INSTR_W-1:0] MemData;
  logic               MemDone;
  logic               MemErr;

  modport master (output MemRd, output MemAddr,
                  input  MemData, input MemDone, input MemErr);
  modport slave  (input  MemRd, input MemAddr,
                  output MemData, output MemDone, output MemErr);
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch FSM, read-request generation, redirect/error priority
module fetch_ctrl
  import wisc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         halt,
  input  logic         redirect,
  input  logic         redirect_odd,
  input  logic         mem_done,
  input  logic         mem_err,
  output fetch_state_t state,
  output logic         mem_rd,
  output logic         accept,
  output logic         hold_ir,
  output logic         load_redirect,
  output logic         err
);

  fetch_state_t next_state;
  logic         set_err;

  // State register and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_FETCH;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (set_err) err <= 1'b1;
    end
  end

  // Next state: redirect beats everything, a faulted read beats a good one
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          next_state = redirect_odd ? ST_HALTED : ST_FETCH;
          set_err    = redirect_odd;
        end else if (mem_done) begin
          next_state = mem_err ? ST_HALTED : ST_VALID;
          set_err    = mem_err;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          next_state = redirect_odd ? ST_HALTED : ST_FETCH;
          set_err    = redirect_odd;
        end else if (stall) begin
          next_state = ST_VALID;
        end else if (halt) begin
          next_state = ST_HALTED;
        end else if (mem_done) begin
          next_state = mem_err ? ST_HALTED : ST_VALID;
          set_err    = mem_err;
        end else begin
          next_state = ST_FETCH;
        end
      end
      default: next_state = ST_HALTED;
    endcase
  end

  // Datapath controls; a same-cycle redirect discards any returned read
  always_comb begin
    mem_rd        = (state == ST_FETCH) || ((state == ST_VALID) && !stall && !halt);
    accept        = mem_rd && mem_done && !mem_err && !redirect;
    hold_ir       = (state == ST_VALID) && stall && !redirect;
    load_redirect = redirect && !redirect_odd && (state != ST_HALTED);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - WISC-SP16 fetch stage: PC, instruction register, incrementer
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               Redirect,
  input  logic [INSTR_W-1:0] RedirectPC,
  fetch_unit_if.master       mem,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] PCPlus2,
  output logic               Halted,
  output logic               Err
);

  fetch_state_t       state;
  logic               accept;
  logic               hold_ir;
  logic               load_redirect;
  logic               mem_rd;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] ir;

  fetch_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .stall         (Stall),
    .halt          (Halt),
    .redirect      (Redirect),
    .redirect_odd  (RedirectPC[0]),
    .mem_done      (mem.MemDone),
    .mem_err       (mem.MemErr),
    .state         (state),
    .mem_rd        (mem_rd),
    .accept        (accept),
    .hold_ir       (hold_ir),
    .load_redirect (load_redirect),
    .err           (Err)
  );

  // PC: redirect target, or advance past each accepted instruction (wraps mod 2^16)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load_redirect) begin
      pc <= RedirectPC;
    end else if (accept) begin
      pc <= pc + 16'd2;
    end
  end

  // IR holds under stall and reverts to NOP whenever no valid instruction remains
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir <= NOP_INSTR;
    end else if (accept) begin
      ir <= mem.MemData;
    end else if (!hold_ir) begin
      ir <= NOP_INSTR;
    end
  end

  assign mem.MemRd   = mem_rd;
  assign mem.MemAddr = pc;
  assign Instr       = ir;
  assign InstrValid  = (state == ST_VALID);
  assign Halted      = (state == ST_HALTED);
  assign PCPlus2     = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Stall = 1'b0;
  logic        Halt = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPC = 16'h0;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [15:0] PCPlus2;
  logic        Halted;
  logic        Err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if mif ();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Halt       (Halt),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .mem        (mif),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PCPlus2    (PCPlus2),
    .Halted     (Halted),
    .Err        (Err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic h, input logic r, input logic [15:0] rpc,
                       input logic d, input logic e, input logic [15:0] dat);
    Stall       = s;
    Halt        = h;
    Redirect    = r;
    RedirectPC  = rpc;
    mif.MemDone = d;
    mif.MemErr  = e;
    mif.MemData = dat;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, Halted, Err, mif.MemRd, mif.MemAddr} !== {1'b0, 16'h0800, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b i=%h h=%b e=%b rd=%b a=%h want v=0 i=0800 h=0 e=0 rd=1 a=0000",
               InstrValid, Instr, Halted, Err, mif.MemRd, mif.MemAddr);
    end
  endtask

  task automatic test_single_cycle;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, 1, 0, 16'h4001 + 16'(i));
      n_checks++;
      if ({mif.MemRd, mif.MemAddr} !== {1'b1, 16'(2 * i)}) begin
        n_fail++;
        $display("FAIL seq_addr%0d got rd=%b a=%h want rd=1 a=%h", i, mif.MemRd, mif.MemAddr, 16'(2 * i));
      end
      if (i > 0) begin
        n_checks++;
        if ({InstrValid, Instr, PCPlus2} !== {1'b1, 16'h4000 + 16'(i), 16'(2 * i)}) begin
          n_fail++;
          $display("FAIL seq_instr%0d got v=%b i=%h p=%h want v=1 i=%h p=%h", i, InstrValid, Instr, PCPlus2,
                   16'h4000 + 16'(i), 16'(2 * i));
        end
      end
      tick;
    end
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, PCPlus2} !== {1'b1, 16'h4003, 16'h0006}) begin
      n_fail++;
      $display("FAIL seq_last got v=%b i=%h p=%h want v=1 i=4003 p=0006", InstrValid, Instr, PCPlus2);
    end
    tick;
  endtask

  task automatic test_stall;
    do_reset;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h4001);
    tick;
    for (int i = 0; i < 3; i++) begin
      // a stray MemDone while MemRd=0 must be ignored
      drive(1, 0, 0, 16'h0, 1, 0, 16'hDEAD);
      n_checks++;
      if ({InstrValid, Instr, PCPlus2, mif.MemAddr, mif.MemRd} !== {1'b1, 16'h4001, 16'h0002, 16'h0002, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_c%0d got v=%b i=%h p=%h a=%h rd=%b want v=1 i=4001 p=0002 a=0002 rd=0",
                 i, InstrValid, Instr, PCPlus2, mif.MemAddr, mif.MemRd);
      end
      tick;
    end
    drive(0, 0, 0, 16'h0, 1, 0, 16'h4002);
    n_checks++;
    if (mif.MemRd !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume_rd got %b want 1", mif.MemRd);
    end
    tick;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, PCPlus2} !== {1'b1, 16'h4002, 16'h0004}) begin
      n_fail++;
      $display("FAIL stall_after got v=%b i=%h p=%h want v=1 i=4002 p=0004", InstrValid, Instr, PCPlus2);
    end
    tick;
  endtask

  task automatic test_redirect;
    do_reset;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h4001);
    tick;
    drive(0, 0, 1, 16'h0100, 1, 0, 16'h4002);
    tick;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h5000);
    n_checks++;
    if ({InstrValid, Instr, mif.MemAddr, mif.MemRd} !== {1'b0, 16'h0800, 16'h0100, 1'b1}) begin
      n_fail++;
      $display("FAIL redir_bubble got v=%b i=%h a=%h rd=%b want v=0 i=0800 a=0100 rd=1",
               InstrValid, Instr, mif.MemAddr, mif.MemRd);
    end
    tick;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, PCPlus2} !== {1'b1, 16'h5000, 16'h0102}) begin
      n_fail++;
      $display("FAIL redir_target got v=%b i=%h p=%h want v=1 i=5000 p=0102", InstrValid, Instr, PCPlus2);
    end
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    drive(0, 0, 1, 16'hFFFE, 0, 0, 16'h0);
    tick;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h6000);
    n_checks++;
    if (mif.MemAddr !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap_addr got %h want fffe", mif.MemAddr);
    end
    tick;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, PCPlus2, Err} !== {1'b1, 16'h6000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_pc got v=%b i=%h p=%h e=%b want v=1 i=6000 p=0000 e=0", InstrValid, Instr, PCPlus2, Err);
    end
    tick;
  endtask

  task automatic test_latency;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, (i == 2), 0, (i == 2) ? 16'h4001 : 16'hBEEF);
      n_checks++;
      if ({mif.MemAddr, mif.MemRd, InstrValid} !== {16'h0000, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL lat_c%0d got a=%h rd=%b v=%b want a=0000 rd=1 v=0", i, mif.MemAddr, mif.MemRd, InstrValid);
      end
      tick;
    end
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({InstrValid, Instr, PCPlus2} !== {1'b1, 16'h4001, 16'h0002}) begin
      n_fail++;
      $display("FAIL lat_done got v=%b i=%h p=%h want v=1 i=4001 p=0002", InstrValid, Instr, PCPlus2);
    end
    tick;
  endtask

  task automatic test_halt;
    do_reset;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h4001);
    tick;
    drive(0, 1, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if (mif.MemRd !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_rd got %b want 0", mif.MemRd);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'h0200, 1, 0, 16'h1111);
      n_checks++;
      if ({Halted, InstrValid, Instr, mif.MemRd, mif.MemAddr, Err} !== {1'b1, 1'b0, 16'h0800, 1'b0, 16'h0002, 1'b0}) begin
        n_fail++;
        $display("FAIL halted_c%0d got h=%b v=%b i=%h rd=%b a=%h e=%b want h=1 v=0 i=0800 rd=0 a=0002 e=0",
                 i, Halted, InstrValid, Instr, mif.MemRd, mif.MemAddr, Err);
      end
      tick;
    end
    do_reset;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({Halted, mif.MemAddr, mif.MemRd} !== {1'b0, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_reset got h=%b a=%h rd=%b want h=0 a=0000 rd=1", Halted, mif.MemAddr, mif.MemRd);
    end
  endtask

  task automatic test_errors;
    do_reset;
    drive(0, 0, 0, 16'h0, 1, 1, 16'h1234);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, 1, 0, 16'h4001);
      n_checks++;
      if ({Err, Halted, InstrValid, Instr, mif.MemRd} !== {1'b1, 1'b1, 1'b0, 16'h0800, 1'b0}) begin
        n_fail++;
        $display("FAIL memerr_c%0d got e=%b h=%b v=%b i=%h rd=%b want e=1 h=1 v=0 i=0800 rd=0",
                 i, Err, Halted, InstrValid, Instr, mif.MemRd);
      end
      tick;
    end
    do_reset;
    drive(0, 0, 0, 16'h0, 1, 0, 16'h4001);
    n_checks++;
    if ({Err, Halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL memerr_reset got e=%b h=%b want e=0 h=0", Err, Halted);
    end
    tick;
    drive(0, 0, 1, 16'h0003, 1, 0, 16'h4002);
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 16'h0010, 1, 0, 16'h4003);
      n_checks++;
      if ({Err, Halted, InstrValid, Instr, mif.MemRd} !== {1'b1, 1'b1, 1'b0, 16'h0800, 1'b0}) begin
        n_fail++;
        $display("FAIL oddpc_c%0d got e=%b h=%b v=%b i=%h rd=%b want e=1 h=1 v=0 i=0800 rd=0",
                 i, Err, Halted, InstrValid, Instr, mif.MemRd);
      end
      tick;
    end
    do_reset;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
    n_checks++;
    if ({Err, Halted, mif.MemAddr} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL oddpc_reset got e=%b h=%b a=%h want e=0 h=0 a=0000", Err, Halted, mif.MemAddr);
    end
  endtask

  initial begin
    mif.MemData = 16'h0;
    mif.MemDone = 1'b0;
    mif.MemErr  = 1'b0;
    test_reset;
    test_single_cycle;
    test_stall;
    test_redirect;
    test_wrap;
    test_latency;
    test_halt;
    test_errors;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
